keypad_time_entry: RTL and testbench
====================================

Name: keypad_time_entry

Overview:
- Sits directly downstream of the keypad press-qualification counter. That counter's `out` drives `key_valid` here; the keypad encoder drives `key_code`.
- Turns each qualified key press into one entry event and shifts decimal digits into a 4-digit MM:SS BCD buffer.
- On START, validates the entry and offers the cook time to the countdown timer over a valid/ready handshake.
- Locks out further entry while the oven runs.

Parameters:
- NUM_DIGITS, 4, number of BCD digits held; buffer width is 4*NUM_DIGITS.
- MAX_SEC_TENS, 5, largest legal seconds-tens digit (digit index 1).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  level from the upstream press counter; high while a qualified key is held.
- key_code  input  4  encoded key: 0-9 digit, 0xA CLEAR/STOP, 0xB START, 0xC-0xF unused.
- time_ready  input  1  timer accepts the offered time.
- oven_done  input  1  one-cycle pulse from the timer: cooking finished or cancel completed.
- disp_bcd  output  16  current entry buffer for the display; digit 0 in [3:0].
- digit_count  output  3  digits entered, 0..NUM_DIGITS.
- time_valid  output  1  offer to timer is pending.
- time_bcd  output  16  offered MM:SS; stable while time_valid is high.
- entry_error  output  1  one-cycle pulse: START rejected.
- cancel  output  1  one-cycle pulse: STOP pressed while running.
- running  output  1  high in RUN.

Behaviour:
- Reset: state ENTRY. Buffer, digit_count, time_bcd, time_valid, entry_error, cancel, running and key_valid_q all 0. Reset mid-offer drops time_valid immediately (asynchronous).
- Event detect:
  - key_valid is registered into key_valid_q.
  - An event occurs when key_valid=1 and key_valid_q=0. key_code is sampled in that same cycle.
  - Exactly one event per press, regardless of hold length.
  - Latency: the effect is visible on outputs at the next posedge.
- ENTRY:
  - Digit event with digit_count<NUM_DIGITS: buffer shifts left one digit, new digit goes into [3:0], digit_count+1.
  - Digit event with digit_count==NUM_DIGITS: ignored; buffer and count unchanged.
  - CLEAR: buffer=0, digit_count=0.
  - START with digit_count==0: ignored, no error.
  - START with buffer digit1>MAX_SEC_TENS: entry_error pulses one cycle; buffer is kept.
  - START otherwise: time_bcd<=buffer, time_valid<=1, go to OFFER.
  - Codes 0xC-0xF: ignored.
- OFFER:
  - time_valid stays high; time_bcd is held.
  - time_ready=1 at posedge: transfer. time_valid<=0, buffer and count cleared, go to RUN.
  - CLEAR event with time_ready=0: abort. time_valid<=0, buffer cleared, go to ENTRY.
  - CLEAR event and time_ready in the same cycle: the transfer wins and the CLEAR is discarded.
  - Digit and START events: ignored.
- RUN:
  - running=1.
  - CLEAR event: cancel pulses one cycle; stay in RUN.
  - oven_done=1: go to ENTRY, running<=0.
  - oven_done coincident with CLEAR: go to ENTRY, no cancel pulse.
  - All other events: ignored.
- disp_bcd shows the buffer in ENTRY, time_bcd in OFFER, and 0 in RUN (the timer owns the display then).
- No arithmetic beyond digit_count increment, which saturates at NUM_DIGITS. Digits are stored raw BCD; the 0-9 range is guaranteed by the key decode.

Decomposition:
- Package oven_pkg holds KEY_CLEAR=4'hA, KEY_START=4'hB, the state enum {ENTRY, OFFER, RUN} (2-bit), and the BCD digit typedef (4-bit).
- One natural sub-module: key_event_detect, containing the key_valid register and the rising-edge pulse plus key_code capture.

Test Plan:
- Reset, then press 1,3,0: rising edges with codes 1,3,0 → disp_bcd=0x0130, digit_count=3; holding key_valid high for 20 cycles adds nothing.
- Press 1,2,3,4,5 → disp_bcd=0x1234, digit_count=4; the fifth digit is ignored. Then CLEAR → disp_bcd=0, digit_count=0.
- Enter 0,1,7,0 then START → entry_error pulses one cycle, time_valid stays 0, disp_bcd stays 0x0170. CLEAR, enter 1,3,0, START → time_valid=1, time_bcd=0x0130.
- With time_valid high and time_ready held 0 for 5 cycles, time_bcd stays 0x0130. time_ready=1 → next cycle time_valid=0, running=1, digit_count=0.
- In OFFER, CLEAR event and time_ready=1 in the same cycle → transfer to RUN, no abort. Separately, CLEAR in OFFER with time_ready=0 → back to ENTRY, time_valid=0.
- In RUN: digit 5 ignored; CLEAR → cancel for exactly 1 cycle; oven_done → ENTRY, running=0. Assert rst_n=0 asynchronously mid-OFFER → time_valid=0 before the next clk edge.

Source files
------------

// File: rtl/oven_pkg.sv
// Shared key codes, entry-FSM states and BCD digit type for the oven keypad front end.
package oven_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_START = 4'hB;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    OFFER = 2'd1,
    RUN   = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Converts the qualified key level into a single-cycle event per press and
// passes the key code through for sampling in that same cycle.
module key_event_detect
  import oven_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_code,
  output logic       o_event,
  output logic [3:0] o_code
);

  logic r_key_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid_q <= 1'b0;
    end else begin
      r_key_valid_q <= i_key_valid;
    end
  end

  assign o_event = i_key_valid & ~r_key_valid_q;
  assign o_code  = i_key_code;

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad MM:SS entry buffer with START validation, valid/ready hand-off of the
// cook time to the countdown timer, and entry lockout while the oven runs.
module keypad_time_entry
  import oven_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int MAX_SEC_TENS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    time_ready,
  input  logic                    oven_done,
  output logic [4*NUM_DIGITS-1:0] disp_bcd,
  output logic [2:0]              digit_count,
  output logic                    time_valid,
  output logic [4*NUM_DIGITS-1:0] time_bcd,
  output logic                    entry_error,
  output logic                    cancel,
  output logic                    running
);

  localparam int         BUF_W        = 4 * NUM_DIGITS;
  localparam logic [2:0] CNT_MAX      = 3'(NUM_DIGITS);
  localparam logic [3:0] SEC_TENS_MAX = 4'(MAX_SEC_TENS);

  logic             w_event;
  logic [3:0]       w_code;

  state_e           r_state;
  logic [BUF_W-1:0] r_buf;
  logic [2:0]       r_count;
  logic [BUF_W-1:0] r_time_bcd;
  logic             r_time_valid;
  logic             r_entry_error;
  logic             r_cancel;

  state_e           w_nxt_state;
  logic [BUF_W-1:0] w_nxt_buf;
  logic [2:0]       w_nxt_count;
  logic [BUF_W-1:0] w_nxt_time_bcd;
  logic             w_nxt_time_valid;
  logic             w_nxt_entry_error;
  logic             w_nxt_cancel;
  logic [BUF_W-1:0] w_disp;

  key_event_detect u_key_event_detect (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_key_valid (key_valid),
    .i_key_code  (key_code),
    .o_event     (w_event),
    .o_code      (w_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ENTRY;
      r_buf         <= '0;
      r_count       <= '0;
      r_time_bcd    <= '0;
      r_time_valid  <= 1'b0;
      r_entry_error <= 1'b0;
      r_cancel      <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_buf         <= w_nxt_buf;
      r_count       <= w_nxt_count;
      r_time_bcd    <= w_nxt_time_bcd;
      r_time_valid  <= w_nxt_time_valid;
      r_entry_error <= w_nxt_entry_error;
      r_cancel      <= w_nxt_cancel;
    end
  end

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_buf         = r_buf;
    w_nxt_count       = r_count;
    w_nxt_time_bcd    = r_time_bcd;
    w_nxt_time_valid  = r_time_valid;
    w_nxt_entry_error = 1'b0;
    w_nxt_cancel      = 1'b0;

    case (r_state)
      ENTRY: begin
        if (w_event) begin
          if (is_digit(w_code)) begin
            if (r_count < CNT_MAX) begin
              w_nxt_buf   = {r_buf[BUF_W-5:0], w_code};
              w_nxt_count = r_count + 3'd1;
            end
          end else if (w_code == KEY_CLEAR) begin
            w_nxt_buf   = '0;
            w_nxt_count = '0;
          end else if ((w_code == KEY_START) && (r_count != 3'd0)) begin
            // Digit 1 is seconds-tens; anything above the limit is not a valid time.
            if (r_buf[7:4] > SEC_TENS_MAX) begin
              w_nxt_entry_error = 1'b1;
            end else begin
              w_nxt_time_bcd   = r_buf;
              w_nxt_time_valid = 1'b1;
              w_nxt_state      = OFFER;
            end
          end
        end
      end

      OFFER: begin
        // An accepted transfer takes priority over a CLEAR in the same cycle.
        if (time_ready) begin
          w_nxt_time_valid = 1'b0;
          w_nxt_buf        = '0;
          w_nxt_count      = '0;
          w_nxt_state      = RUN;
        end else if (w_event && (w_code == KEY_CLEAR)) begin
          w_nxt_time_valid = 1'b0;
          w_nxt_buf        = '0;
          w_nxt_count      = '0;
          w_nxt_state      = ENTRY;
        end
      end

      RUN: begin
        if (oven_done) begin
          w_nxt_state = ENTRY;
        end else if (w_event && (w_code == KEY_CLEAR)) begin
          w_nxt_cancel = 1'b1;
        end
      end

      default: begin
        w_nxt_state = ENTRY;
      end
    endcase
  end

  always_comb begin
    w_disp = '0;
    case (r_state)
      ENTRY:   w_disp = r_buf;
      OFFER:   w_disp = r_time_bcd;
      default: w_disp = '0;
    endcase
  end

  assign disp_bcd    = w_disp;
  assign digit_count = r_count;
  assign time_valid  = r_time_valid;
  assign time_bcd    = r_time_bcd;
  assign entry_error = r_entry_error;
  assign cancel      = r_cancel;
  assign running     = (r_state == RUN);

endmodule

// File: tb/tb_keypad_time_entry.sv
// Self-checking bench for keypad_time_entry: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a digit-list reference model.
module tb_keypad_time_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        time_ready = 1'b0;
  logic        oven_done = 1'b0;
  logic [15:0] disp_bcd;
  logic [2:0]  digit_count;
  logic        time_valid;
  logic [15:0] time_bcd;
  logic        entry_error;
  logic        cancel;
  logic        running;

  int errors = 0;
  int checks = 0;

  keypad_time_entry #(.NUM_DIGITS(4), .MAX_SEC_TENS(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .time_ready  (time_ready),
    .oven_done   (oven_done),
    .disp_bcd    (disp_bcd),
    .digit_count (digit_count),
    .time_valid  (time_valid),
    .time_bcd    (time_bcd),
    .entry_error (entry_error),
    .cancel      (cancel),
    .running     (running)
  );

  always #5 clk = ~clk;

  // {disp, count, time_valid, time_bcd, entry_error, cancel, running}
  logic [38:0] act;
  assign act = {disp_bcd, digit_count, time_valid, time_bcd, entry_error, cancel, running};

  function automatic logic [38:0] pk(input logic [15:0] d, input logic [2:0] c, input logic tv,
                                     input logic [15:0] tb, input logic e, input logic ca,
                                     input logic r);
    return {d, c, tv, tb, e, ca, r};
  endfunction

  task automatic check(input string name, input logic [38:0] got, input logic [38:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got disp=%h cnt=%0d tv=%b tbcd=%h err=%b cancel=%b run=%b, expected disp=%h cnt=%0d tv=%b tbcd=%h err=%b cancel=%b run=%b",
               name, got[38:23], got[22:20], got[19], got[18:3], got[2], got[1], got[0],
               exp[38:23], exp[22:20], exp[19], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] code, input logic tr, input logic od);
    key_valid  = kv;
    key_code   = code;
    time_ready = tr;
    oven_done  = od;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        kv;
    logic [3:0]  code;
    logic        tr;
    logic        od;
    logic [38:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic kv, input logic [3:0] code, input logic tr, input logic od,
                     input logic [15:0] d, input logic [2:0] c, input logic tv,
                     input logic [15:0] tb, input logic e, input logic ca, input logic r);
    vec_t v;
    v.kv = kv; v.code = code; v.tr = tr; v.od = od;
    v.exp = pk(d, c, tv, tb, e, ca, r);
    tbl.push_back(v);
  endtask

  // A press is one cycle high then one cycle low; pulses last only the first cycle.
  task automatic add_press(input logic [3:0] code, input logic [15:0] d, input logic [2:0] c,
                           input logic tv, input logic [15:0] tb, input logic e,
                           input logic ca, input logic r);
    add(1'b1, code, 1'b0, 1'b0, d, c, tv, tb, e, ca, r);
    add(1'b0, 4'h0, 1'b0, 1'b0, d, c, tv, tb, 1'b0, 1'b0, r);
  endtask

  // ---------------- reference model ----------------
  int          m_mode;          // 0 entering, 1 offering, 2 running
  logic [3:0]  m_digs[$];
  logic [15:0] m_tbcd;
  logic        m_tv, m_err, m_cancel, m_kvq;

  function automatic logic [15:0] digs_value();
    logic [15:0] v = 16'h0;
    foreach (m_digs[i]) v = (v << 4) | 16'(m_digs[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_digs.delete(); m_tbcd = 16'h0;
    m_tv = 0; m_err = 0; m_cancel = 0; m_kvq = 0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] code, input logic tr, input logic od);
    logic ev;
    logic [3:0] tens;
    ev = kv && !m_kvq;
    m_kvq = kv;
    m_err = 0;
    m_cancel = 0;
    if (m_mode == 0) begin
      if (ev) begin
        if (code < 4'd10) begin
          if (m_digs.size() < 4) m_digs.push_back(code);
        end else if (code == 4'hA) begin
          m_digs.delete();
        end else if (code == 4'hB && m_digs.size() > 0) begin
          tens = (m_digs.size() >= 2) ? m_digs[m_digs.size()-2] : 4'h0;
          if (tens > 4'd5) m_err = 1;
          else begin
            m_tbcd = digs_value();
            m_tv = 1;
            m_mode = 1;
          end
        end
      end
    end else if (m_mode == 1) begin
      if (tr) begin
        m_tv = 0; m_digs.delete(); m_mode = 2;
      end else if (ev && code == 4'hA) begin
        m_tv = 0; m_digs.delete(); m_mode = 0;
      end
    end else begin
      if (od) m_mode = 0;
      else if (ev && code == 4'hA) m_cancel = 1;
    end
  endtask

  function automatic logic [38:0] model_out();
    logic [15:0] d;
    d = (m_mode == 0) ? digs_value() : (m_mode == 1) ? m_tbcd : 16'h0;
    return pk(d, 3'(m_digs.size()), m_tv, m_tbcd, m_err, m_cancel, m_mode == 2);
  endfunction

  initial begin
    logic kv, tr, od;
    logic [3:0] code;
    int r;

    // ---- reset ----
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset", act, pk(16'h0, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table: digit entry, saturation, clear, start rules, run ----
    add_press(4'h1, 16'h0001, 3'd1, 0, 16'h0, 0, 0, 0);
    add_press(4'h3, 16'h0013, 3'd2, 0, 16'h0, 0, 0, 0);
    add(1, 4'h0, 0, 0, 16'h0130, 3'd3, 0, 16'h0, 0, 0, 0);
    add(1, 4'h7, 0, 0, 16'h0130, 3'd3, 0, 16'h0, 0, 0, 0);
    add(0, 4'h0, 0, 0, 16'h0130, 3'd3, 0, 16'h0, 0, 0, 0);
    add_press(4'h4, 16'h1304, 3'd4, 0, 16'h0, 0, 0, 0);
    add_press(4'h5, 16'h1304, 3'd4, 0, 16'h0, 0, 0, 0);
    add_press(4'hA, 16'h0000, 3'd0, 0, 16'h0, 0, 0, 0);
    add_press(4'hB, 16'h0000, 3'd0, 0, 16'h0, 0, 0, 0);
    add_press(4'h0, 16'h0000, 3'd1, 0, 16'h0, 0, 0, 0);
    add_press(4'h1, 16'h0001, 3'd2, 0, 16'h0, 0, 0, 0);
    add_press(4'h7, 16'h0017, 3'd3, 0, 16'h0, 0, 0, 0);
    add_press(4'h0, 16'h0170, 3'd4, 0, 16'h0, 0, 0, 0);
    add_press(4'hB, 16'h0170, 3'd4, 0, 16'h0, 1, 0, 0);
    add_press(4'hC, 16'h0170, 3'd4, 0, 16'h0, 0, 0, 0);
    add_press(4'hA, 16'h0000, 3'd0, 0, 16'h0, 0, 0, 0);
    add_press(4'h1, 16'h0001, 3'd1, 0, 16'h0, 0, 0, 0);
    add_press(4'h3, 16'h0013, 3'd2, 0, 16'h0, 0, 0, 0);
    add_press(4'h0, 16'h0130, 3'd3, 0, 16'h0, 0, 0, 0);
    add_press(4'hB, 16'h0130, 3'd3, 1, 16'h0130, 0, 0, 0);
    add_press(4'h9, 16'h0130, 3'd3, 1, 16'h0130, 0, 0, 0);
    add(0, 4'h0, 1, 0, 16'h0000, 3'd0, 0, 16'h0130, 0, 0, 1);
    add_press(4'h5, 16'h0000, 3'd0, 0, 16'h0130, 0, 0, 1);
    add_press(4'hA, 16'h0000, 3'd0, 0, 16'h0130, 0, 1, 1);
    add(0, 4'h0, 0, 1, 16'h0000, 3'd0, 0, 16'h0130, 0, 0, 0);
    // CLEAR coincident with ready: transfer wins
    add_press(4'h2, 16'h0002, 3'd1, 0, 16'h0130, 0, 0, 0);
    add_press(4'hB, 16'h0002, 3'd1, 1, 16'h0002, 0, 0, 0);
    add(1, 4'hA, 1, 0, 16'h0000, 3'd0, 0, 16'h0002, 0, 0, 1);
    add(0, 4'h0, 0, 0, 16'h0000, 3'd0, 0, 16'h0002, 0, 0, 1);
    add(0, 4'h0, 0, 1, 16'h0000, 3'd0, 0, 16'h0002, 0, 0, 0);
    // CLEAR without ready aborts the offer
    add_press(4'h4, 16'h0004, 3'd1, 0, 16'h0002, 0, 0, 0);
    add_press(4'hB, 16'h0004, 3'd1, 1, 16'h0004, 0, 0, 0);
    add_press(4'hA, 16'h0000, 3'd0, 0, 16'h0004, 0, 0, 0);
    add(0, 4'h0, 1, 0, 16'h0000, 3'd0, 0, 16'h0004, 0, 0, 0);
    // Seconds-tens boundary: 6 rejected, 5 accepted
    add_press(4'h0, 16'h0000, 3'd1, 0, 16'h0004, 0, 0, 0);
    add_press(4'h6, 16'h0006, 3'd2, 0, 16'h0004, 0, 0, 0);
    add_press(4'h0, 16'h0060, 3'd3, 0, 16'h0004, 0, 0, 0);
    add_press(4'hB, 16'h0060, 3'd3, 0, 16'h0004, 1, 0, 0);
    add_press(4'hA, 16'h0000, 3'd0, 0, 16'h0004, 0, 0, 0);
    add_press(4'h0, 16'h0000, 3'd1, 0, 16'h0004, 0, 0, 0);
    add_press(4'h5, 16'h0005, 3'd2, 0, 16'h0004, 0, 0, 0);
    add_press(4'h9, 16'h0059, 3'd3, 0, 16'h0004, 0, 0, 0);
    add_press(4'hB, 16'h0059, 3'd3, 1, 16'h0059, 0, 0, 0);
    add(0, 4'h0, 1, 0, 16'h0000, 3'd0, 0, 16'h0059, 0, 0, 1);
    // oven_done with CLEAR: leave RUN without a cancel pulse
    add(1, 4'hA, 0, 1, 16'h0000, 3'd0, 0, 16'h0059, 0, 0, 0);
    add(0, 4'h0, 0, 0, 16'h0000, 3'd0, 0, 16'h0059, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].kv, tbl[i].code, tbl[i].tr, tbl[i].od);
      check($sformatf("vec%0d", i), act, tbl[i].exp);
    end

    // ---- long hold produces one event only ----
    step(1, 4'h1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 4'($urandom_range(0, 9)), 0, 0);
    check("hold20", act, pk(16'h0001, 3'd1, 0, 16'h0059, 0, 0, 0));
    step(0, 4'h0, 0, 0);
    step(1, 4'h3, 0, 0); step(0, 4'h0, 0, 0);
    step(1, 4'h0, 0, 0); step(0, 4'h0, 0, 0);
    step(1, 4'hB, 0, 0); step(0, 4'h0, 0, 0);
    check("offer_start", act, pk(16'h0130, 3'd3, 1, 16'h0130, 0, 0, 0));

    // ---- offer held while ready stays low ----
    for (int i = 0; i < 5; i++) begin
      step(0, 4'h0, 0, 0);
      check($sformatf("offer_hold%0d", i), act, pk(16'h0130, 3'd3, 1, 16'h0130, 0, 0, 0));
    end
    step(0, 4'h0, 1, 0);
    check("offer_take", act, pk(16'h0000, 3'd0, 0, 16'h0130, 0, 0, 1));
    step(0, 4'h0, 0, 1);
    check("done", act, pk(16'h0000, 3'd0, 0, 16'h0130, 0, 0, 0));

    // ---- asynchronous reset mid-offer ----
    step(1, 4'h2, 0, 0); step(0, 4'h0, 0, 0);
    step(1, 4'hB, 0, 0); step(0, 4'h0, 0, 0);
    check("pre_async", act, pk(16'h0002, 3'd1, 1, 16'h0002, 0, 0, 0));
    #3 rst_n = 1'b0;
    #1;
    check("async_rst", act, pk(16'h0, 3'd0, 0, 16'h0, 0, 0, 0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- randomized traffic against the reference model ----
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      kv = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 99);
      if (r < 60)      code = 4'($urandom_range(0, 9));
      else if (r < 75) code = 4'hA;
      else if (r < 95) code = 4'hB;
      else             code = 4'($urandom_range(12, 15));
      tr = ($urandom_range(0, 3) == 0);
      od = ($urandom_range(0, 15) == 0);
      model_step(kv, code, tr, od);
      step(kv, code, tr, od);
      check($sformatf("rand%0d", i), act, model_out());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
